// File: rtl/trisc_mem_arbiter_pkg.sv
// rtl/trisc_mem_arbiter_pkg.sv - shared types and defaults for the TRISC memory arbiter
package trisc_pkg;

  localparam int AW_DEF = 8;
  localparam int DW_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } arb_state_e;

  typedef enum logic {
    REQ_CPU = 1'b0,
    REQ_PNL = 1'b1
  } req_id_e;

endpackage

// File: rtl/trisc_mem_arbiter_if.sv
// rtl/trisc_mem_arbiter_if.sv - requester, memory and status signals of the TRISC memory arbiter
interface trisc_mem_arbiter_if
  import trisc_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
);

  logic          CpuReq;
  logic          CpuWe;
  logic [AW-1:0] CpuAddr;
  logic [DW-1:0] CpuWData;
  logic          CpuAck;
  logic [DW-1:0] CpuRData;

  logic          PnlReq;
  logic          PnlWe;
  logic [AW-1:0] PnlAddr;
  logic [DW-1:0] PnlWData;
  logic          PnlAck;
  logic [DW-1:0] PnlRData;

  logic          MemEn;
  logic          MemWe;
  logic [AW-1:0] MemAddr;
  logic [DW-1:0] MemWData;
  logic [DW-1:0] MemRData;

  logic          Busy;

  // Environment side: control unit, front panel and the memory macro.
  modport master (
    output CpuReq, CpuWe, CpuAddr, CpuWData,
    input  CpuAck, CpuRData,
    output PnlReq, PnlWe, PnlAddr, PnlWData,
    input  PnlAck, PnlRData,
    input  MemEn, MemWe, MemAddr, MemWData,
    output MemRData,
    input  Busy
  );

  // Arbiter side.
  modport slave (
    input  CpuReq, CpuWe, CpuAddr, CpuWData,
    output CpuAck, CpuRData,
    input  PnlReq, PnlWe, PnlAddr, PnlWData,
    output PnlAck, PnlRData,
    output MemEn, MemWe, MemAddr, MemWData,
    input  MemRData,
    output Busy
  );

endinterface

// File: rtl/trisc_mem_arbiter.sv
// rtl/trisc_mem_arbiter.sv - serialises CPU and front-panel accesses onto the single memory port
module trisc_mem_arbiter
  import trisc_pkg::*;
#(
  parameter int AW       = AW_DEF,
  parameter int DW       = DW_DEF,
  parameter int MEM_LAT  = 1,
  parameter int CPU_PRIO = 0
) (
  input  logic                SysClock,
  input  logic                StartStop,
  trisc_mem_arbiter_if.slave  bus
);

  // Counter reload so that capture lands MEM_LAT cycles after ISSUE.
  localparam logic [3:0] LAT_RELOAD = 4'(MEM_LAT - 1);

  arb_state_e    state;
  arb_state_e    state_nxt;
  logic [3:0]    lat_cnt;
  logic [3:0]    lat_cnt_nxt;
  req_id_e       last_win;
  req_id_e       win;
  logic          grant;
  req_id_e       grant_id;
  logic          capture;

  logic          lat_we;
  logic [AW-1:0] lat_addr;
  logic [DW-1:0] lat_wdata;
  logic [DW-1:0] cpu_rdata;
  logic [DW-1:0] pnl_rdata;

  // Next-state, arbitration decision and read-capture strobe.
  always_comb begin
    state_nxt   = state;
    lat_cnt_nxt = lat_cnt;
    grant       = 1'b0;
    grant_id    = REQ_CPU;
    capture     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.CpuReq && bus.PnlReq) begin
          grant = 1'b1;
          if (CPU_PRIO != 0) begin
            grant_id = REQ_CPU;
          end else begin
            grant_id = (last_win == REQ_CPU) ? REQ_PNL : REQ_CPU;
          end
        end else if (bus.CpuReq) begin
          grant    = 1'b1;
          grant_id = REQ_CPU;
        end else if (bus.PnlReq) begin
          grant    = 1'b1;
          grant_id = REQ_PNL;
        end
        if (grant) begin
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        lat_cnt_nxt = LAT_RELOAD;
        state_nxt   = WAIT;
      end
      WAIT: begin
        if (lat_cnt == 4'd0) begin
          capture   = ~lat_we;
          state_nxt = DONE;
        end else begin
          lat_cnt_nxt = lat_cnt - 4'd1;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State register and latency counter.
  always_ff @(posedge SysClock) begin
    if (!StartStop) begin
      state   <= IDLE;
      lat_cnt <= 4'd0;
    end else begin
      state   <= state_nxt;
      lat_cnt <= lat_cnt_nxt;
    end
  end

  // Winner bookkeeping, request latches and per-requester read data.
  always_ff @(posedge SysClock) begin
    if (!StartStop) begin
      last_win  <= REQ_PNL;
      win       <= REQ_CPU;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      cpu_rdata <= '0;
      pnl_rdata <= '0;
    end else begin
      if (grant) begin
        win      <= grant_id;
        last_win <= grant_id;
        if (grant_id == REQ_CPU) begin
          lat_we    <= bus.CpuWe;
          lat_addr  <= bus.CpuAddr;
          lat_wdata <= bus.CpuWData;
        end else begin
          lat_we    <= bus.PnlWe;
          lat_addr  <= bus.PnlAddr;
          lat_wdata <= bus.PnlWData;
        end
      end
      if (capture) begin
        if (win == REQ_CPU) begin
          cpu_rdata <= bus.MemRData;
        end else begin
          pnl_rdata <= bus.MemRData;
        end
      end
    end
  end

  // Memory strobe is a pure state decode so an ISSUE already underway reaches the macro.
  assign bus.MemEn    = (state == ISSUE);
  assign bus.MemWe    = lat_we;
  assign bus.MemAddr  = lat_addr;
  assign bus.MemWData = lat_wdata;
  assign bus.CpuAck   = (state == DONE) && (win == REQ_CPU);
  assign bus.PnlAck   = (state == DONE) && (win == REQ_PNL);
  assign bus.CpuRData = cpu_rdata;
  assign bus.PnlRData = pnl_rdata;
  assign bus.Busy     = (state != IDLE);

endmodule

// File: tb/tb_trisc_mem_arbiter.sv
// tb/tb_trisc_mem_arbiter.sv - self-checking bench for trisc_mem_arbiter
`timescale 1ns/1ps
module tb_trisc_mem_arbiter;

  localparam int N = 3;

  // Instance 0: MEM_LAT=1 round-robin; 1: MEM_LAT=3 round-robin; 2: MEM_LAT=1 CPU priority.
  function automatic int lat_of(input int g);
    return (g == 1) ? 3 : 1;
  endfunction

  function automatic int prio_of(input int g);
    return (g == 2) ? 1 : 0;
  endfunction

  function automatic logic [7:0] preload(input int i);
    if (i == 'h12) return 8'hA5;
    return 8'(i) ^ 8'h5A;
  endfunction

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       rstn      [N];
  logic       cpu_req   [N];
  logic       cpu_we    [N];
  logic [7:0] cpu_addr  [N];
  logic [7:0] cpu_wdata [N];
  logic       pnl_req   [N];
  logic       pnl_we    [N];
  logic [7:0] pnl_addr  [N];
  logic [7:0] pnl_wdata [N];
  logic       cpu_ack   [N];
  logic [7:0] cpu_rdata [N];
  logic       pnl_ack   [N];
  logic [7:0] pnl_rdata [N];
  logic       mem_en    [N];
  logic       mem_we    [N];
  logic [7:0] mem_addr  [N];
  logic [7:0] mem_wdata [N];
  logic       busy      [N];

  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int L = (g == 1) ? 3 : 1;
    localparam int P = (g == 2) ? 1 : 0;

    trisc_mem_arbiter_if #(.AW(8), .DW(8)) bus ();

    logic [7:0] mem  [256];
    logic [7:0] pipe [L];
    logic       loaded = 1'b0;

    assign bus.CpuReq   = cpu_req[g];
    assign bus.CpuWe    = cpu_we[g];
    assign bus.CpuAddr  = cpu_addr[g];
    assign bus.CpuWData = cpu_wdata[g];
    assign bus.PnlReq   = pnl_req[g];
    assign bus.PnlWe    = pnl_we[g];
    assign bus.PnlAddr  = pnl_addr[g];
    assign bus.PnlWData = pnl_wdata[g];
    assign bus.MemRData = pipe[L-1];
    assign cpu_ack[g]   = bus.CpuAck;
    assign cpu_rdata[g] = bus.CpuRData;
    assign pnl_ack[g]   = bus.PnlAck;
    assign pnl_rdata[g] = bus.PnlRData;
    assign mem_en[g]    = bus.MemEn;
    assign mem_we[g]    = bus.MemWe;
    assign mem_addr[g]  = bus.MemAddr;
    assign mem_wdata[g] = bus.MemWData;
    assign busy[g]      = bus.Busy;

    trisc_mem_arbiter #(.AW(8), .DW(8), .MEM_LAT(L), .CPU_PRIO(P)) dut (
      .SysClock (clk),
      .StartStop(rstn[g]),
      .bus      (bus)
    );

    // Memory macro: read data appears L cycles after the strobe, garbage otherwise.
    always @(posedge clk) begin
      if (!loaded) begin
        for (int i = 0; i < 256; i++) mem[i] <= preload(i);
        loaded <= 1'b1;
      end else if (bus.MemEn && bus.MemWe) begin
        mem[bus.MemAddr] <= bus.MemWData;
      end
      pipe[0] <= (bus.MemEn && !bus.MemWe) ? mem[bus.MemAddr] : 8'hEE;
      for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
    end
  end

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input int g, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s[%0d] @cyc %0d: got %0h want %0h", nm, g, cyc, got, want);
    end
  endtask

  // Transaction model: an access occupies 3+LAT cycles counted from the granting edge.
  logic [7:0] mm      [N][256];
  bit         act     [N];
  int         el      [N];
  bit         lw      [N];
  bit         mwin    [N];
  logic       mwe     [N];
  logic [7:0] maddr   [N];
  logic [7:0] mwd     [N];
  logic [7:0] exp_crd [N];
  logic [7:0] exp_prd [N];

  always @(posedge clk) begin
    for (int g = 0; g < N; g++) begin
      if (act[g] && el[g] == 1 && mwe[g]) mm[g][maddr[g]] = mwd[g];
      if (!rstn[g]) begin
        act[g] = 1'b0; el[g] = 0; lw[g] = 1'b1; mwin[g] = 1'b0;
        mwe[g] = 1'b0; maddr[g] = 8'h00; mwd[g] = 8'h00;
        exp_crd[g] = 8'h00; exp_prd[g] = 8'h00;
      end else if (act[g]) begin
        if (el[g] == 2 + lat_of(g)) begin
          act[g] = 1'b0;
        end else begin
          el[g]++;
          if (el[g] == 2 + lat_of(g) && !mwe[g]) begin
            if (mwin[g]) exp_prd[g] = mm[g][maddr[g]];
            else         exp_crd[g] = mm[g][maddr[g]];
          end
        end
      end else if (cpu_req[g] || pnl_req[g]) begin
        if (cpu_req[g] && pnl_req[g]) mwin[g] = (prio_of(g) != 0) ? 1'b0 : ~lw[g];
        else                          mwin[g] = pnl_req[g];
        lw[g]    = mwin[g];
        mwe[g]   = mwin[g] ? pnl_we[g]    : cpu_we[g];
        maddr[g] = mwin[g] ? pnl_addr[g]  : cpu_addr[g];
        mwd[g]   = mwin[g] ? pnl_wdata[g] : cpu_wdata[g];
        act[g]   = 1'b1;
        el[g]    = 1;
      end
    end
  end

  // Every-cycle comparison of all DUT outputs against the model.
  always @(negedge clk) begin
    if (cyc > 0) begin
      for (int g = 0; g < N; g++) begin
        chk("busy",      g, busy[g],      act[g]);
        chk("mem_en",    g, mem_en[g],    act[g] && el[g] == 1);
        chk("mem_we",    g, mem_we[g],    mwe[g]);
        chk("mem_addr",  g, mem_addr[g],  maddr[g]);
        chk("mem_wdata", g, mem_wdata[g], mwd[g]);
        chk("cpu_ack",   g, cpu_ack[g],   act[g] && el[g] == 2 + lat_of(g) && !mwin[g]);
        chk("pnl_ack",   g, pnl_ack[g],   act[g] && el[g] == 2 + lat_of(g) && mwin[g]);
        chk("cpu_rdata", g, cpu_rdata[g], exp_crd[g]);
        chk("pnl_rdata", g, pnl_rdata[g], exp_prd[g]);
      end
    end
  end

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic do_req(input int g, input bit pnl, input logic we, input logic [7:0] addr,
                        input logic [7:0] wd, output int lat, output logic [7:0] rd);
    bit seen;
    seen = 1'b0;
    lat  = -1;
    rd   = 8'h00;
    if (pnl) begin
      pnl_req[g] = 1'b1; pnl_we[g] = we; pnl_addr[g] = addr; pnl_wdata[g] = wd;
    end else begin
      cpu_req[g] = 1'b1; cpu_we[g] = we; cpu_addr[g] = addr; cpu_wdata[g] = wd;
    end
    for (int k = 1; k <= 30 && !seen; k++) begin
      tick();
      if (pnl ? pnl_ack[g] : cpu_ack[g]) begin
        seen = 1'b1;
        lat  = k;
        rd   = pnl ? pnl_rdata[g] : cpu_rdata[g];
      end
    end
    if (pnl) pnl_req[g] = 1'b0;
    else     cpu_req[g] = 1'b0;
    chk("ack_seen", g, seen, 1);
    tick();
  endtask

  int         lat;
  logic [7:0] rd;
  int         who  [4];
  int         when [4];
  int         nacks;
  int         ncpu;
  int         k;

  initial begin
    for (int g = 0; g < N; g++) begin
      for (int i = 0; i < 256; i++) mm[g][i] = preload(i);
      rstn[g] = 1'b0;
      cpu_req[g] = 1'b0; cpu_we[g] = 1'b0; cpu_addr[g] = 8'h00; cpu_wdata[g] = 8'h00;
      pnl_req[g] = 1'b0; pnl_we[g] = 1'b0; pnl_addr[g] = 8'h00; pnl_wdata[g] = 8'h00;
    end

    // Reset then idle.
    tick(); tick();
    for (int g = 0; g < N; g++) rstn[g] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle_busy",  0, busy[0],   0);
      chk("idle_memen", 0, mem_en[0], 0);
      chk("idle_acks",  0, {cpu_ack[0], pnl_ack[0]}, 0);
      chk("idle_rdata", 0, {cpu_rdata[0], pnl_rdata[0]}, 0);
    end

    // CPU read of preloaded 0x12 at MEM_LAT=1.
    cpu_req[0] = 1'b1; cpu_we[0] = 1'b0; cpu_addr[0] = 8'h12;
    tick();
    chk("rd_memen", 0, mem_en[0], 1);
    chk("rd_maddr", 0, mem_addr[0], 8'h12);
    tick();
    chk("rd_noack_early", 0, cpu_ack[0], 0);
    tick();
    chk("rd_ack",   0, cpu_ack[0], 1);
    chk("rd_data",  0, cpu_rdata[0], 8'hA5);
    chk("rd_pnlack", 0, pnl_ack[0], 0);
    cpu_req[0] = 1'b0;
    tick();

    // Panel write then CPU read-back at MEM_LAT=3.
    do_req(1, 1'b1, 1'b1, 8'h07, 8'h3C, lat, rd);
    chk("pw_lat", 1, lat, 5);
    do_req(1, 1'b0, 1'b0, 8'h07, 8'h00, lat, rd);
    chk("cr_lat",  1, lat, 5);
    chk("cr_data", 1, rd, 8'h3C);

    // Round-robin with both requests held.
    rstn[0] = 1'b0; tick(); tick(); rstn[0] = 1'b1;
    cpu_req[0] = 1'b1; cpu_we[0] = 1'b0; cpu_addr[0] = 8'h30;
    pnl_req[0] = 1'b1; pnl_we[0] = 1'b0; pnl_addr[0] = 8'h31;
    for (int i = 0; i < 4; i++) begin who[i] = -1; when[i] = -1; end
    nacks = 0; k = 0;
    while (nacks < 4 && k < 40) begin
      tick(); k++;
      chk("rr_single_ack", 0, cpu_ack[0] & pnl_ack[0], 0);
      if (cpu_ack[0] || pnl_ack[0]) begin who[nacks] = int'(pnl_ack[0]); when[nacks] = k; nacks++; end
    end
    cpu_req[0] = 1'b0; pnl_req[0] = 1'b0;
    tick();
    chk("rr_count", 0, nacks, 4);
    for (int i = 0; i < 4; i++) begin
      chk("rr_who",  0, who[i],  i % 2);
      chk("rr_when", 0, when[i], 3 + 4 * i);
    end

    // CPU priority: three CPU wins, then the panel.
    cpu_req[2] = 1'b1; cpu_we[2] = 1'b0; cpu_addr[2] = 8'h40;
    pnl_req[2] = 1'b1; pnl_we[2] = 1'b0; pnl_addr[2] = 8'h41;
    for (int i = 0; i < 4; i++) begin who[i] = -1; when[i] = -1; end
    nacks = 0; ncpu = 0; k = 0;
    while (nacks < 4 && k < 40) begin
      tick(); k++;
      if (cpu_ack[2] || pnl_ack[2]) begin who[nacks] = int'(pnl_ack[2]); when[nacks] = k; nacks++; end
      if (cpu_ack[2]) begin ncpu++; if (ncpu == 3) cpu_req[2] = 1'b0; end
      if (pnl_ack[2]) pnl_req[2] = 1'b0;
    end
    cpu_req[2] = 1'b0; pnl_req[2] = 1'b0;
    tick();
    chk("pr_count", 2, nacks, 4);
    for (int i = 0; i < 4; i++) begin
      chk("pr_who",  2, who[i],  (i == 3) ? 1 : 0);
      chk("pr_when", 2, when[i], 3 + 4 * i);
    end
    chk("pr_pnl_data", 2, pnl_rdata[2], 8'h41 ^ 8'h5A);

    // Reset during WAIT abandons the access.
    cpu_req[1] = 1'b1; cpu_we[1] = 1'b0; cpu_addr[1] = 8'h20;
    tick();
    chk("rst_issue", 1, mem_en[1], 1);
    tick();
    rstn[1] = 1'b0; cpu_req[1] = 1'b0;
    tick();
    rstn[1] = 1'b1;
    chk("rst_busy",  1, busy[1], 0);
    chk("rst_rdata", 1, cpu_rdata[1], 0);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("rst_noack", 1, {cpu_ack[1], pnl_ack[1]}, 0);
    end
    do_req(1, 1'b0, 1'b0, 8'h20, 8'h00, lat, rd);
    chk("rst_fresh_lat",  1, lat, 5);
    chk("rst_fresh_data", 1, rd, 8'h7A);

    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
